ext_mem_responder: RTL
======================

# ext_mem_responder

Slave-side model and controller for the processor's external memory bus. It answers `ext_mem_enable` / `ext_mem_read` / `ext_mem_write` requests from `microprocessor_system` with a programmable wait-state latency and a one-cycle `ext_mem_ready` acknowledge. It backs the requests with a word-addressed RAM and drives or samples the shared bidirectional `ext_data` bus. It replaces the constant-ready tie-off in system benches and is the synthesizable external memory for FPGA builds.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: byte address of word 0 of the window.
- `DEPTH_WORDS`, default 4096: RAM depth in 32-bit words (power of two).
- `WAIT_STATES`, default 2: cycles inserted between request acceptance and acknowledge (0–15).
- `ERR_PATTERN`, default 32'hDEAD_BEEF: read data returned for out-of-window or illegal accesses.
- `clk`  in  1: system clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ext_addr`  in  32: byte address from the CPU; bits [1:0] are ignored.
- `ext_data`  inout  32: shared data bus. Driven by the block only in RESP with a read; high-Z otherwise.
- `ext_mem_read`  in  1: read strobe.
- `ext_mem_write`  in  1: write strobe.
- `ext_mem_enable`  in  1: request valid.
- `ext_mem_ready`  out  1: acknowledge, high for exactly one cycle per request.
- `bus_error`  out  1: sticky error flag, cleared only by reset.
- `access_count`  out  32: completed-transaction counter, wraps modulo 2^32.

## Operation
- FSM states: IDLE, WAIT, RESP, HOLD.
- **IDLE**
  - A request is `ext_mem_enable`=1 together with `ext_mem_read`=1 or `ext_mem_write`=1.
  - On the first rising edge that sees a request, latch the word index `(ext_addr-BASE_ADDR)>>2`, the read/write kind, `ext_data` (for writes), and an error bit.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES`>0, else go to RESP.
  - `ext_mem_enable`=1 with neither strobe set is ignored.
- **Error bit** is set when either:
  - the address is outside [`BASE_ADDR`, `BASE_ADDR`+4·`DEPTH_WORDS`); or
  - read and write are asserted together.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - Strobe and address changes during WAIT are ignored, because the values latched in IDLE govern the transaction.
- **RESP**
  - `ext_mem_ready`=1 for this cycle.
  - Read: drive RAM data onto `ext_data`, or `ERR_PATTERN` if the error bit is set.
  - Write: commit the latched data on the edge leaving RESP. An error write is dropped.
  - On that same edge: `access_count`+1, and `bus_error`←1 if the error bit is set.
  - Next state is HOLD if `ext_mem_enable` is still 1, else IDLE.
- **HOLD**: wait for `ext_mem_enable`=0, then go to IDLE. This prevents one long strobe from being serviced twice.
- Reset mid-transaction:
  - FSM returns to IDLE, `ext_mem_ready`=0, `ext_data` goes high-Z.
  - A pending write is discarded and the counter is not incremented.
  - RAM contents are not cleared.

## Timing
- Reset values:
  - `ext_mem_ready`=0, `bus_error`=0, `access_count`=0.
  - `ext_data` high-Z, FSM=IDLE.
- Latency: request sampled at edge k → `ext_mem_ready` high in the cycle following edge k+`WAIT_STATES`.
  - `WAIT_STATES`=0 → ready in the cycle right after the accepting edge.
- `ext_mem_ready` and the `ext_data` drive enable are Moore outputs decoded from RESP, with no combinational path from the inputs.
- Read data is valid on `ext_data` throughout the ready cycle. The CPU samples it on the edge that ends that cycle.
- Back-to-back transactions: minimum spacing is `WAIT_STATES`+2 cycles (accept, wait, RESP, IDLE), which requires the CPU to drop enable during RESP.
- Write and read to the same word in consecutive transactions: the read returns the new data, because the write commits before the next acceptance.

## Structure
- Package `ext_mem_pkg`:
  - FSM state encoding (2-bit: IDLE=0, WAIT=1, RESP=2, HOLD=3).
  - `ERR_PATTERN` default.
  - Wait-counter width constant (4).
- Sub-module `ext_mem_array`:
  - `DEPTH_WORDS`×32 RAM with synchronous write and asynchronous read.
  - Bench preload through `$readmemh` on its memory array.
- Top level holds the FSM, address decode, tri-state driver and counters.

## Test plan
- **Zero-wait read:** `WAIT_STATES`=0, preload word 0=32'h0000_2710; read 0x0001_0000 → ready high exactly 1 cycle after acceptance; `ext_data`=32'h0000_2710; `access_count`=1.
- **Wait-state write/read:** `WAIT_STATES`=2; write 32'h0001_3880 to 0x0001_0004, then read it back → each ready arrives 3 cycles after its request edge; read returns 32'h0001_3880; `access_count`=2.
- **Held strobe:** keep `ext_mem_enable`=1 for 10 cycles on a single read → exactly one ready pulse; FSM sits in HOLD until enable drops.
- **Out-of-window access:** read 0x0000_2000 → `ext_data`=32'hDEAD_BEEF with ready; `bus_error`=1 and stays 1; write 0x0002_0000 leaves RAM unchanged.
- **Illegal strobes:** read and write together at 0x0001_0008 → ready pulse, no RAM change, `bus_error`=1. Enable with neither strobe for 5 cycles → no ready, count unchanged.
- **Reset mid-WAIT:** `WAIT_STATES`=5; assert `rst` during a write's WAIT → ready never pulses; target word keeps its old value; `access_count`=0; bus high-Z.

Source files
------------

// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - shared types and constants for the external memory responder
package ext_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] ERR_PATTERN_DEFAULT = 32'hDEAD_BEEF;
    localparam int          WAIT_CNT_W          = 4;

endpackage

// File: rtl/ext_mem_array.sv
// rtl/ext_mem_array.sv - word-addressed RAM, synchronous write, asynchronous read
//
// Ports:
//   clk   : write clock
//   we    : write enable, commits wdata to mem[addr] on the rising edge
//   addr  : word index shared by read and write
//   wdata : write data
//   rdata : combinational read of mem[addr]
module ext_mem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // No reset: contents survive a controller reset.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ext_mem_responder.sv
// rtl/ext_mem_responder.sv - external memory bus slave with programmable wait states
//
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   ext_addr        : byte address, bits [1:0] ignored
//   ext_data        : shared bidirectional data bus, driven only while answering a read
//   ext_mem_read    : read strobe
//   ext_mem_write   : write strobe
//   ext_mem_enable  : request valid
//   ext_mem_ready   : one-cycle acknowledge per request
//   bus_error       : sticky error flag
//   access_count    : completed-transaction counter
module ext_mem_responder
    import ext_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ERR_PATTERN = ERR_PATTERN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ext_addr,
    inout  wire  [31:0] ext_data,
    input  logic        ext_mem_read,
    input  logic        ext_mem_write,
    input  logic        ext_mem_enable,
    output logic        ext_mem_ready,
    output logic        bus_error,
    output logic [31:0] access_count
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [AW-1:0]         word_idx;
    logic                  req_write;
    logic                  req_err;
    logic [31:0]           req_data;

    logic [31:0] offset;
    logic        in_window;
    logic        is_req;
    logic        mem_we;
    logic        data_oe;
    logic [31:0] rdata;

    assign offset    = ext_addr - BASE_ADDR;
    assign in_window = (ext_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    assign is_req    = ext_mem_enable && (ext_mem_read || ext_mem_write);

    // Outputs decode from the state register only, so no input reaches them combinationally.
    assign ext_mem_ready = (state == ST_RESP);
    assign data_oe       = (state == ST_RESP) && !req_write;
    assign mem_we        = (state == ST_RESP) && req_write && !req_err;
    assign ext_data      = data_oe ? (req_err ? ERR_PATTERN : rdata) : 32'bz;

    ext_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (word_idx),
        .wdata (req_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            word_idx     <= '0;
            req_write    <= 1'b0;
            req_err      <= 1'b0;
            req_data     <= '0;
            bus_error    <= 1'b0;
            access_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_req) begin
                        word_idx  <= offset[AW+1:2];
                        // Both strobes together is an error access answered like a read.
                        req_write <= ext_mem_write && !ext_mem_read;
                        req_err   <= !in_window || (ext_mem_read && ext_mem_write);
                        req_data  <= ext_data;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == 1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    access_count <= access_count + 1'b1;
                    if (req_err) begin
                        bus_error <= 1'b1;
                    end
                    state <= ext_mem_enable ? ST_HOLD : ST_IDLE;
                end
                ST_HOLD: begin
                    if (!ext_mem_enable) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
